// File: rtl/ripple_accumulator_ctrl_pkg.sv
// Shared opcodes, FSM state encoding and timer width for the ripple accumulator controller.
package ripple_accumulator_ctrl_pkg;

    localparam logic [1:0] OP_NOP   = 2'd0;
    localparam logic [1:0] OP_CLEAR = 2'd1;
    localparam logic [1:0] OP_LOAD  = 2'd2;
    localparam logic [1:0] OP_ADD   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2
    } state_e;

    // Wide enough for the largest legal settle count (15).
    localparam int unsigned TIMER_W = 4;

endpackage

// File: rtl/ripple_accumulator_ctrl_settle_timer.sv
// Loadable down-counter that times how long the adder operands are held before sampling.
module settle_timer
    import ripple_accumulator_ctrl_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic zero
);

    localparam logic [TIMER_W-1:0] LoadVal = TIMER_W'(SETTLE_CYCLES - 1);

    logic [TIMER_W-1:0] cnt_q, cnt_d;

    // Next count: load wins over decrement; never underflows below zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LoadVal;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - TIMER_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/ripple_accumulator_ctrl.sv
// Command-driven running-sum unit wrapped around an external 4-bit ripple-carry adder.
module ripple_accumulator_ctrl
    import ripple_accumulator_ctrl_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [3:0]       cmd_data,
    output logic             a1,
    output logic             a2,
    output logic             a3,
    output logic             a4,
    output logic             b1,
    output logic             b2,
    output logic             b3,
    output logic             b4,
    input  logic             s1,
    input  logic             s2,
    input  logic             s3,
    input  logic             s4,
    output logic [3:0]       acc,
    output logic             wrap,
    output logic [CNT_W-1:0] add_cnt,
    output logic             done
);

    state_e             state_q, state_d;
    logic [3:0]         acc_q, acc_d;
    logic [3:0]         b_q, b_d;
    logic               wrap_q, wrap_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               tmr_load, tmr_dec, tmr_zero;
    logic [3:0]         sum;

    assign sum = {s4, s3, s2, s1};

    settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle_timer (
        .clk  (clk),
        .rst  (rst),
        .load (tmr_load),
        .dec  (tmr_dec),
        .zero (tmr_zero)
    );

    // Command decode in IDLE, operand hold in SETTLE, sum sampling in CAPTURE.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        b_d      = b_q;
        wrap_d   = wrap_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_NOP: ;
                        OP_CLEAR: begin
                            acc_d  = '0;
                            b_d    = '0;
                            wrap_d = 1'b0;
                            cnt_d  = '0;
                            done_d = 1'b1;
                        end
                        OP_LOAD: begin
                            acc_d  = cmd_data;
                            done_d = 1'b1;
                        end
                        OP_ADD: begin
                            b_d      = cmd_data;
                            tmr_load = 1'b1;
                            state_d  = ST_SETTLE;
                        end
                        default: ;
                    endcase
                end
            end
            ST_SETTLE: begin
                if (tmr_zero) begin
                    state_d = ST_CAPTURE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_CAPTURE: begin
                acc_d = sum;
                // No carry-out from the adder, so a smaller result is the only wrap evidence.
                if (sum < acc_q) begin
                    wrap_d = 1'b1;
                end
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            b_q     <= '0;
            wrap_q  <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            wrap_q  <= wrap_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign {a4, a3, a2, a1} = acc_q;
    assign {b4, b3, b2, b1} = b_q;
    assign acc     = acc_q;
    assign wrap    = wrap_q;
    assign add_cnt = cnt_q;
    assign done    = done_q;

endmodule

// File: tb/tb_ripple_accumulator_ctrl.sv
// Scoreboard bench: driver updates a behavioural model and queues expected completions,
// a monitor pops them when done pulses.
module tb_ripple_accumulator_ctrl;

    localparam int S  = 2;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [3:0]    cmd_data;
    logic          a1, a2, a3, a4, b1, b2, b3, b4, s1, s2, s3, s4;
    logic [3:0]    acc;
    logic          wrap;
    logic [CW-1:0] add_cnt;
    logic          done;

    always #5 clk = ~clk;

    ripple_accumulator_ctrl #(
        .SETTLE_CYCLES(S),
        .CNT_W        (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .a1 (a1), .a2 (a2), .a3 (a3), .a4 (a4),
        .b1 (b1), .b2 (b2), .b3 (b3), .b4 (b4),
        .s1 (s1), .s2 (s2), .s3 (s3), .s4 (s4),
        .acc       (acc),
        .wrap      (wrap),
        .add_cnt   (add_cnt),
        .done      (done)
    );

    // Stand-in for the external combinational adder.
    logic [3:0] sum_w;
    assign sum_w = {a4, a3, a2, a1} + {b4, b3, b2, b1};
    assign {s4, s3, s2, s1} = sum_w;

    typedef struct {
        logic [3:0]    acc;
        logic          wrap;
        logic [CW-1:0] cnt;
        int            done_edge;
    } exp_t;

    exp_t q[$];

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    logic [3:0]    m_acc, m_b;
    logic          m_wrap;
    logic [CW-1:0] m_cnt;
    int            ready_at;
    int            n_vec = 0;
    int            n_err = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (edge %0d)", nm, act, exp, edge_cnt);
        end
    endtask

    task automatic model_reset();
        m_acc  = '0;
        m_b    = '0;
        m_wrap = 1'b0;
        m_cnt  = '0;
    endtask

    // One cycle of stimulus: check visible state against the model, then drive.
    task automatic step(input logic v, input logic [1:0] op, input logic [3:0] d,
                        output logic took);
        exp_t e;
        logic rdy;
        @(negedge clk);
        rdy = (edge_cnt >= ready_at);
        chk("cmd_ready", int'(cmd_ready), int'(rdy));
        if (rdy) begin
            chk("acc_idle", int'(acc), int'(m_acc));
            chk("wrap_idle", int'(wrap), int'(m_wrap));
            chk("cnt_idle", int'(add_cnt), int'(m_cnt));
        end else begin
            chk("b_hold", int'({b4, b3, b2, b1}), int'(m_b));
        end
        cmd_valid = v;
        cmd_op    = op;
        cmd_data  = d;
        took = v && rdy;
        if (took && op != 2'd0) begin
            e.done_edge = edge_cnt + 1;
            case (op)
                2'd1: begin
                    model_reset();
                end
                2'd2: begin
                    m_acc = d;
                end
                default: begin
                    if (int'(m_acc) + int'(d) > 15) m_wrap = 1'b1;
                    m_acc = 4'((int'(m_acc) + int'(d)) % 16);
                    m_b   = d;
                    if (m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
                    e.done_edge = edge_cnt + 1 + S + 1;
                end
            endcase
            ready_at = e.done_edge;
            e.acc  = m_acc;
            e.wrap = m_wrap;
            e.cnt  = m_cnt;
            q.push_back(e);
        end
    endtask

    task automatic cmd(input logic [1:0] op, input logic [3:0] d);
        logic took;
        int n = 0;
        do begin
            step(1'b1, op, d, took);
            n++;
        end while (!took && n < 50);
        chk("cmd_accept", int'(took), 1);
    endtask

    task automatic idle(input int n);
        logic took;
        for (int i = 0; i < n; i++) step(1'b0, 2'd0, 4'd0, took);
    endtask

    // Monitor: done must pulse exactly on the queued edge, carrying the queued result.
    always @(negedge clk) begin
        if (!rst) begin
            if (q.size() > 0 && q[0].done_edge == edge_cnt) begin
                chk("done_pulse", int'(done), 1);
                chk("acc_done", int'(acc), int'(q[0].acc));
                chk("wrap_done", int'(wrap), int'(q[0].wrap));
                chk("cnt_done", int'(add_cnt), int'(q[0].cnt));
                void'(q.pop_front());
            end else begin
                chk("done_quiet", int'(done), 0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1);
    end

    initial begin
        logic took;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_data  = 4'd0;
        model_reset();
        ready_at = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        ready_at = edge_cnt;
        chk("rst_b", int'({b4, b3, b2, b1}), 0);
        chk("rst_done", int'(done), 0);
        idle(1);

        // LOAD 5, ADD 3.
        cmd(2'd2, 4'd5);
        cmd(2'd3, 4'd3);
        idle(4);
        chk("add_5_3", int'(acc), 8);

        // Wrap and stickiness.
        cmd(2'd2, 4'd15);
        cmd(2'd3, 4'd1);
        cmd(2'd3, 4'd2);
        idle(4);
        chk("wrap_sticky", int'(wrap), 1);

        // ADD 0 never wraps.
        cmd(2'd1, 4'd0);
        cmd(2'd2, 4'd9);
        cmd(2'd3, 4'd0);
        idle(4);

        // Second ADD held valid through SETTLE.
        cmd(2'd1, 4'd0);
        cmd(2'd3, 4'd4);
        cmd(2'd3, 4'd7);
        idle(4);
        chk("held_add", int'(acc), 11);

        // Reset during SETTLE.
        cmd(2'd2, 4'd10);
        cmd(2'd3, 4'd6);
        idle(1);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_acc", int'(acc), 0);
        chk("mid_rst_wrap", int'(wrap), 0);
        chk("mid_rst_cnt", int'(add_cnt), 0);
        chk("mid_rst_b", int'({b4, b3, b2, b1}), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_ready", int'(cmd_ready), 1);
        q.delete();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        ready_at = edge_cnt;
        idle(4);

        // Counter saturation.
        cmd(2'd1, 4'd0);
        for (int i = 0; i < 256; i++) cmd(2'd3, 4'd1);
        idle(4);
        chk("sat_cnt", int'(add_cnt), 255);
        chk("sat_acc", int'(acc), 0);
        chk("sat_wrap", int'(wrap), 1);

        // Random traffic, including commands offered while busy.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                 4'($urandom_range(0, 15)), took);
        end
        cmd_valid = 1'b0;
        idle(S + 4);
        chk("queue_drained", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
